// File: rtl/btb_update_if.sv
// Bundle between the IF/EX pipeline stages and the BTB update unit: fetch-side
// PHT lookup, EX-side resolution inputs, and BTB write / redirect / statistics outputs.
interface btb_update_if #(
    parameter int BTB_INDEX_WIDTH = 5,
    parameter int TAG_WIDTH       = 25
);
    logic [31:0]                if_pc;
    logic [BTB_INDEX_WIDTH-1:0] if_pht_index;
    logic                       if_pred_taken;

    logic                       ex_valid;
    logic                       ex_stall;
    logic [31:0]                ex_pc;
    logic                       ex_is_branch;
    logic                       ex_is_jump;
    logic                       ex_taken;
    logic [31:0]                ex_target;
    logic                       ex_pred_taken;
    logic [31:0]                ex_pred_target;
    logic [BTB_INDEX_WIDTH-1:0] ex_pht_index;

    logic                       update_tag;
    logic [BTB_INDEX_WIDTH-1:0] update_index;
    logic [TAG_WIDTH-1:0]       update_tag_value;
    logic [31:0]                update_target;
    logic                       mispredict;
    logic [31:0]                redirect_pc;
    logic [31:0]                branch_count;
    logic [31:0]                mispredict_count;

    modport master (
        output if_pc,
        input  if_pht_index, if_pred_taken,
        output ex_valid, ex_stall, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
        output ex_target, ex_pred_taken, ex_pred_target, ex_pht_index,
        input  update_tag, update_index, update_tag_value, update_target,
        input  mispredict, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc,
        output if_pht_index, if_pred_taken,
        input  ex_valid, ex_stall, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
        input  ex_target, ex_pred_taken, ex_pred_target, ex_pht_index,
        output update_tag, update_index, update_tag_value, update_target,
        output mispredict, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/btb_update_unit.sv
// EX-stage branch resolution and predictor update: gshare PHT/BHR, BTB write side,
// mispredict redirect and control-flow statistics.
module btb_update_unit #(
    parameter int BTB_INDEX_WIDTH = 5,
    parameter int TAG_WIDTH       = 25
) (
    input  logic         clk,
    input  logic         reset,
    btb_update_if.slave  bus
);
    localparam int IW    = BTB_INDEX_WIDTH;
    localparam int TW    = TAG_WIDTH;
    localparam int DEPTH = 1 << IW;

    logic [1:0]    pht [DEPTH];
    logic [IW-1:0] bhr;
    logic [31:0]   branch_count_q;
    logic [31:0]   mispredict_count_q;

    logic          cf;
    logic          cond_branch;
    logic [31:0]   pc_plus4;
    logic [31:0]   actual_next;
    logic [31:0]   pred_next;
    logic          wrong_path;
    logic [IW-1:0] fetch_index;

    // A simultaneous branch+jump flag decodes as a jump.
    assign cf          = bus.ex_valid & ~bus.ex_stall & (bus.ex_is_branch | bus.ex_is_jump);
    assign cond_branch = bus.ex_is_branch & ~bus.ex_is_jump;

    assign pc_plus4    = bus.ex_pc + 32'd4;
    assign actual_next = bus.ex_taken      ? bus.ex_target      : pc_plus4;
    assign pred_next   = bus.ex_pred_taken ? bus.ex_pred_target : pc_plus4;
    assign wrong_path  = (actual_next != pred_next);

    // The fetch lookup sees the table before this cycle's EX write lands.
    assign fetch_index       = bus.if_pc[IW+1:2] ^ bhr;
    assign bus.if_pht_index  = fetch_index;
    assign bus.if_pred_taken = pht[fetch_index][1];

    assign bus.mispredict       = cf & ~reset & wrong_path;
    assign bus.redirect_pc      = actual_next;
    assign bus.update_tag       = cf & ~reset & bus.ex_taken;
    assign bus.update_index     = bus.ex_pc[IW+1:2];
    assign bus.update_tag_value = bus.ex_pc[31:IW+2];
    assign bus.update_target    = bus.ex_target;

    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
            bhr                <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (cf) begin
            if (cond_branch) begin
                if (bus.ex_taken) begin
                    if (pht[bus.ex_pht_index] != 2'b11) begin
                        pht[bus.ex_pht_index] <= pht[bus.ex_pht_index] + 2'd1;
                    end
                end else begin
                    if (pht[bus.ex_pht_index] != 2'b00) begin
                        pht[bus.ex_pht_index] <= pht[bus.ex_pht_index] - 2'd1;
                    end
                end
                bhr <= {bhr[IW-2:0], bus.ex_taken};
            end else begin
                pht[bus.ex_pht_index] <= 2'b11;
            end
            branch_count_q <= branch_count_q + 32'd1;
            if (wrong_path) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end
endmodule
